// File: rtl/dense_seq_pkg.sv
// Shared types, constants and the int8 requantization helper for the dense layer sequencer.
package dense_seq_pkg;

   localparam int unsigned MAX_IN     = 256;
   localparam int unsigned MAX_OUT    = 64;
   localparam int unsigned BANK_SIZE  = 256;
   localparam int unsigned ACC_W      = 32;
   localparam int unsigned VEC_LEN    = 64;
   localparam int unsigned IN_SIZE_W  = 9;
   localparam int unsigned OUT_SIZE_W = 7;
   localparam int unsigned SHIFT_W    = 5;
   localparam int unsigned ADDR_W     = 9;
   localparam int unsigned DATA_W     = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_ISSUE,
      ST_WAIT,
      ST_WRITEBACK,
      ST_NEXT,
      ST_DONE
   } dense_seq_state_t;

   // Arithmetic shift (floor), optional ReLU, then saturate to int8.
   function automatic logic [DATA_W-1:0] requant_int8(
      input logic signed [ACC_W-1:0]   acc,
      input logic        [SHIFT_W-1:0] shift,
      input logic                      relu
   );
      logic signed [ACC_W-1:0] s;
      s = acc >>> shift;
      if (relu && (s < 0)) begin
         s = '0;
      end
      if (s > 32'sd127) begin
         return 8'h7F;
      end else if (s < -32'sd128) begin
         return 8'h80;
      end
      return s[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/dense_layer_sequencer_if.sv
// Compute-block handshake and tensor RAM write port seen by the sequencer.
interface dense_layer_sequencer_if;
   import dense_seq_pkg::*;

   logic                          dc_start_compute;
   logic                          dc_input_valid;
   logic [IN_SIZE_W-1:0]          dc_input_size;
   logic [OUT_SIZE_W-1:0]         dc_output_size;
   logic                          dc_computation_complete;
   logic signed [ACC_W-1:0]       dc_output_vector [VEC_LEN];
   logic                          rd_bank;
   logic                          tram_we;
   logic [ADDR_W-1:0]             tram_waddr;
   logic [DATA_W-1:0]             tram_wdata;

   // Sequencer side
   modport master (
      output dc_start_compute, dc_input_valid, dc_input_size, dc_output_size,
      output rd_bank, tram_we, tram_waddr, tram_wdata,
      input  dc_computation_complete, dc_output_vector
   );

   // Compute block / tensor RAM side
   modport slave (
      input  dc_start_compute, dc_input_valid, dc_input_size, dc_output_size,
      input  rd_bank, tram_we, tram_waddr, tram_wdata,
      output dc_computation_complete, dc_output_vector
   );

endinterface

// File: rtl/dense_requant.sv
// Combinational requantization of one accumulator to int8.
module dense_requant
   import dense_seq_pkg::*;
(
   input  logic signed [ACC_W-1:0]   acc,
   input  logic        [SHIFT_W-1:0] shift,
   input  logic                      relu,
   output logic        [DATA_W-1:0]  result_c
);

   // Thin wrapper so the function can be exercised on its own.
   always_comb begin
      result_c = requant_int8(acc, shift, relu);
   end

endmodule

// File: rtl/dense_layer_sequencer.sv
// Runs a chain of dense layers through one compute block, requantizing and
// writing each layer's output into the opposite ping-pong tensor RAM bank.
module dense_layer_sequencer #(
   parameter int unsigned MAX_LAYERS = 4,
   parameter int unsigned MAX_IN     = 256,
   parameter int unsigned MAX_OUT    = 64
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic [$clog2(MAX_LAYERS+1)-1:0]       num_layers,
   input  logic [8:0]                            cfg_input_size  [MAX_LAYERS],
   input  logic [6:0]                            cfg_output_size [MAX_LAYERS],
   input  logic [4:0]                            cfg_shift       [MAX_LAYERS],
   input  logic                                  cfg_relu        [MAX_LAYERS],
   dense_layer_sequencer_if.master               dc,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  error,
   output logic [$clog2(MAX_LAYERS)-1:0]         layer_idx,
   output logic                                  result_bank
);
   import dense_seq_pkg::*;

   localparam int unsigned NL_W = $clog2(MAX_LAYERS + 1);
   localparam int unsigned LI_W = $clog2(MAX_LAYERS);
   localparam int unsigned WB_W = $clog2(VEC_LEN);

   dense_seq_state_t        state_q, state_d;
   logic [NL_W-1:0]         layer_q, layer_d;
   logic [NL_W-1:0]         num_layers_q, num_layers_d;
   logic [WB_W-1:0]         wb_idx_q, wb_idx_d;
   logic [IN_SIZE_W-1:0]    cfg_in_q    [MAX_LAYERS];
   logic [IN_SIZE_W-1:0]    cfg_in_d    [MAX_LAYERS];
   logic [OUT_SIZE_W-1:0]   cfg_out_q   [MAX_LAYERS];
   logic [OUT_SIZE_W-1:0]   cfg_out_d   [MAX_LAYERS];
   logic [SHIFT_W-1:0]      cfg_shift_q [MAX_LAYERS];
   logic [SHIFT_W-1:0]      cfg_shift_d [MAX_LAYERS];
   logic                    cfg_relu_q  [MAX_LAYERS];
   logic                    cfg_relu_d  [MAX_LAYERS];
   logic                    rd_bank_q, rd_bank_d;
   logic                    error_q, error_d;
   logic                    result_bank_q, result_bank_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    issue_q, issue_d;
   logic                    tram_we_q, tram_we_d;
   logic [ADDR_W-1:0]       tram_waddr_q, tram_waddr_d;
   logic [IN_SIZE_W-1:0]    in_size_q, in_size_d;
   logic [OUT_SIZE_W-1:0]   out_size_q, out_size_d;

   logic [LI_W-1:0]         cur_c;
   logic [LI_W-1:0]         prev_c;
   logic                    cfg_bad_c;
   logic [DATA_W-1:0]       wdata_c;

   // Requantize the accumulator addressed by the current writeback index.
   dense_requant u_requant (
      .acc      (dc.dc_output_vector[wb_idx_q]),
      .shift    (cfg_shift_q[cur_c]),
      .relu     (cfg_relu_q[cur_c]),
      .result_c (wdata_c)
   );

   // Next-state, datapath updates and registered-output decode.
   always_comb begin
      state_d       = state_q;
      layer_d       = layer_q;
      num_layers_d  = num_layers_q;
      wb_idx_d      = wb_idx_q;
      cfg_in_d      = cfg_in_q;
      cfg_out_d     = cfg_out_q;
      cfg_shift_d   = cfg_shift_q;
      cfg_relu_d    = cfg_relu_q;
      rd_bank_d     = rd_bank_q;
      error_d       = error_q;
      result_bank_d = result_bank_q;

      cur_c  = layer_q[LI_W-1:0];
      prev_c = LI_W'(cur_c - LI_W'(1));

      // A layer is unusable if its sizes are out of range or don't chain.
      cfg_bad_c = (num_layers_q > NL_W'(MAX_LAYERS))
               || (cfg_in_q[cur_c] == '0)
               || (cfg_in_q[cur_c] > IN_SIZE_W'(MAX_IN))
               || (cfg_out_q[cur_c] == '0)
               || (cfg_out_q[cur_c] > OUT_SIZE_W'(MAX_OUT))
               || ((layer_q != '0) && (cfg_in_q[cur_c] != IN_SIZE_W'(cfg_out_q[prev_c])));

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               cfg_in_d      = cfg_input_size;
               cfg_out_d     = cfg_output_size;
               cfg_shift_d   = cfg_shift;
               cfg_relu_d    = cfg_relu;
               num_layers_d  = num_layers;
               result_bank_d = num_layers[0];
               layer_d       = '0;
               rd_bank_d     = 1'b0;
               error_d       = 1'b0;
               state_d       = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (num_layers_q == '0) begin
               state_d = ST_DONE;
            end else if (cfg_bad_c) begin
               error_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (dc.dc_computation_complete) begin
               wb_idx_d = '0;
               state_d  = ST_WRITEBACK;
            end
         end
         ST_WRITEBACK: begin
            if (wb_idx_q == WB_W'(cfg_out_q[cur_c] - OUT_SIZE_W'(1))) begin
               state_d = ST_NEXT;
            end else begin
               wb_idx_d = wb_idx_q + WB_W'(1);
            end
         end
         ST_NEXT: begin
            layer_d   = layer_q + NL_W'(1);
            rd_bank_d = ~rd_bank_q;
            state_d   = (layer_d == num_layers_q) ? ST_DONE : ST_CHECK;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_d == ST_DONE);
      issue_d      = (state_d == ST_ISSUE);
      tram_we_d    = (state_d == ST_WRITEBACK);
      tram_waddr_d = {~rd_bank_d, 8'(wb_idx_d)};
      in_size_d    = cfg_in_d[layer_d[LI_W-1:0]];
      out_size_d   = cfg_out_d[layer_d[LI_W-1:0]];
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         layer_q       <= '0;
         num_layers_q  <= '0;
         wb_idx_q      <= '0;
         cfg_in_q      <= '{default: '0};
         cfg_out_q     <= '{default: '0};
         cfg_shift_q   <= '{default: '0};
         cfg_relu_q    <= '{default: 1'b0};
         rd_bank_q     <= 1'b0;
         error_q       <= 1'b0;
         result_bank_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         issue_q       <= 1'b0;
         tram_we_q     <= 1'b0;
         tram_waddr_q  <= '0;
         in_size_q     <= '0;
         out_size_q    <= '0;
      end else begin
         state_q       <= state_d;
         layer_q       <= layer_d;
         num_layers_q  <= num_layers_d;
         wb_idx_q      <= wb_idx_d;
         cfg_in_q      <= cfg_in_d;
         cfg_out_q     <= cfg_out_d;
         cfg_shift_q   <= cfg_shift_d;
         cfg_relu_q    <= cfg_relu_d;
         rd_bank_q     <= rd_bank_d;
         error_q       <= error_d;
         result_bank_q <= result_bank_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         issue_q       <= issue_d;
         tram_we_q     <= tram_we_d;
         tram_waddr_q  <= tram_waddr_d;
         in_size_q     <= in_size_d;
         out_size_q    <= out_size_d;
      end
   end

   assign dc.dc_start_compute = issue_q;
   assign dc.dc_input_valid   = issue_q;
   assign dc.dc_input_size    = in_size_q;
   assign dc.dc_output_size   = out_size_q;
   assign dc.rd_bank          = rd_bank_q;
   assign dc.tram_we          = tram_we_q;
   assign dc.tram_waddr       = tram_waddr_q;
   assign dc.tram_wdata       = wdata_c;
   assign busy                = busy_q;
   assign done                = done_q;
   assign error               = error_q;
   assign layer_idx           = layer_q[LI_W-1:0];
   assign result_bank         = result_bank_q;

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Directed bench for dense_layer_sequencer with a small compute-block responder.
module tb_dense_layer_sequencer;
   import dense_seq_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] num_layers;
   logic [8:0] cfg_input_size  [4];
   logic [6:0] cfg_output_size [4];
   logic [4:0] cfg_shift       [4];
   logic       cfg_relu        [4];
   logic       busy, done, error, result_bank;
   logic [1:0] layer_idx;

   dense_layer_sequencer_if dc_if ();

   dense_layer_sequencer #(.MAX_LAYERS(4), .MAX_IN(256), .MAX_OUT(64)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .num_layers      (num_layers),
      .cfg_input_size  (cfg_input_size),
      .cfg_output_size (cfg_output_size),
      .cfg_shift       (cfg_shift),
      .cfg_relu        (cfg_relu),
      .dc              (dc_if),
      .busy            (busy),
      .done            (done),
      .error           (error),
      .layer_idx       (layer_idx),
      .result_bank     (result_bank)
   );

   always #5 clk = ~clk;

   int err_cnt   = 0;
   int chk_cnt   = 0;
   int start_cnt = 0;
   int done_cnt  = 0;
   int start_base, done_base, wr_base, rdb_base;
   int cm_cnt    = 0;
   int vec_tbl [4][64];
   logic [8:0] wr_addr_q [$];
   logic [7:0] wr_data_q [$];
   logic       rdb_log   [$];
   logic [8:0] exp_a     [$];
   logic [7:0] exp_d     [$];
   bit         seen;
   logic       err_at_done;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Compute-block responder: completes 3 cycles after start, holds vector until next start.
   always @(negedge clk) begin
      if (reset) begin
         cm_cnt = 0;
         dc_if.dc_computation_complete = 1'b0;
      end else begin
         dc_if.dc_computation_complete = 1'b0;
         if (dc_if.dc_start_compute) begin
            rdb_log.push_back(dc_if.rd_bank);
            if (start_cnt - start_base < 4)
               for (int i = 0; i < 64; i++)
                  dc_if.dc_output_vector[i] = vec_tbl[start_cnt - start_base][i];
            start_cnt++;
            cm_cnt = 3;
         end else if (cm_cnt > 0) begin
            cm_cnt--;
            if (cm_cnt == 0) dc_if.dc_computation_complete = 1'b1;
         end
      end
   end

   // Tensor RAM write and done monitor.
   always @(negedge clk) begin
      if (!reset) begin
         if (dc_if.tram_we) begin
            wr_addr_q.push_back(dc_if.tram_waddr);
            wr_data_q.push_back(dc_if.tram_wdata);
         end
         if (done) done_cnt++;
      end
   end

   task automatic set_layer(input int l, input int in_sz, input int out_sz, input int sh, input bit relu);
      cfg_input_size[l]  = 9'(in_sz);
      cfg_output_size[l] = 7'(out_sz);
      cfg_shift[l]       = 5'(sh);
      cfg_relu[l]        = relu;
   endtask

   task automatic launch();
      start_base = start_cnt;
      done_base  = done_cnt;
      wr_base    = wr_addr_q.size();
      rdb_base   = rdb_log.size();
      exp_a.delete();
      exp_d.delete();
      start = 1'b1;
      @(posedge clk) #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc);
      seen = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (done) begin
            seen = 1'b1;
            err_at_done = error;
            break;
         end
         @(posedge clk) #1;
      end
      check_eq("done_seen", 32'(seen), 1);
      @(posedge clk) #1;
      check_eq("done_one_cycle", 32'(done), 0);
      check_eq("done_count", 32'(done_cnt - done_base), 1);
   endtask

   task automatic expect_wr(input int a, input int d);
      exp_a.push_back(9'(a));
      exp_d.push_back(8'(d));
   endtask

   task automatic cmp_writes(input string tag);
      int n;
      n = wr_addr_q.size() - wr_base;
      check_eq({tag, "_wr_count"}, 32'(n), 32'(exp_a.size()));
      for (int i = 0; i < n && i < exp_a.size(); i++) begin
         check_eq($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[wr_base + i]), 32'(exp_a[i]));
         check_eq($sformatf("%s_data%0d", tag, i), 32'(wr_data_q[wr_base + i]), 32'(exp_d[i]));
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"}, 32'(busy), 0);
      check_eq({tag, "_done"}, 32'(done), 0);
      check_eq({tag, "_error"}, 32'(error), 0);
      check_eq({tag, "_we"}, 32'(dc_if.tram_we), 0);
      check_eq({tag, "_dcstart"}, 32'(dc_if.dc_start_compute), 0);
      check_eq({tag, "_dcvalid"}, 32'(dc_if.dc_input_valid), 0);
      check_eq({tag, "_rdbank"}, 32'(dc_if.rd_bank), 0);
      check_eq({tag, "_layer"}, 32'(layer_idx), 0);
      check_eq({tag, "_resbank"}, 32'(result_bank), 0);
   endtask

   task automatic setup_t1();
      for (int l = 0; l < 4; l++) set_layer(l, 1, 1, 0, 1'b0);
      set_layer(0, 4, 2, 0, 1'b0);
      num_layers = 3'd1;
      vec_tbl[0][0] = 5;
      vec_tbl[0][1] = -3;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      setup_t1();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b0;
      @(posedge clk) #1;

      // T1: single layer, cycle-accurate issue timing
      launch();
      check_eq("t1_check_busy", 32'(busy), 1);
      check_eq("t1_check_nostart", 32'(dc_if.dc_start_compute), 0);
      @(posedge clk) #1;
      check_eq("t1_issue_start", 32'(dc_if.dc_start_compute), 1);
      check_eq("t1_issue_valid", 32'(dc_if.dc_input_valid), 1);
      check_eq("t1_in_size", 32'(dc_if.dc_input_size), 4);
      check_eq("t1_out_size", 32'(dc_if.dc_output_size), 2);
      @(posedge clk) #1;
      check_eq("t1_start_pulse_end", 32'(dc_if.dc_start_compute), 0);
      wait_done(100);
      expect_wr(256, 8'h05);
      expect_wr(257, 8'hFD);
      cmp_writes("t1");
      check_eq("t1_result_bank", 32'(result_bank), 1);
      check_eq("t1_error", 32'(err_at_done), 0);
      check_eq("t1_busy_after", 32'(busy), 0);

      // T2: requant corners, shift 4, without then with ReLU
      for (int r = 0; r < 2; r++) begin
         set_layer(0, 4, 4, 4, r[0]);
         num_layers = 3'd1;
         vec_tbl[0][0] = 32'h7FFF;
         vec_tbl[0][1] = -4096;
         vec_tbl[0][2] = -17;
         vec_tbl[0][3] = 40;
         launch();
         wait_done(100);
         expect_wr(256, 8'h7F);
         expect_wr(257, (r == 0) ? 8'h80 : 8'h00);
         expect_wr(258, (r == 0) ? 8'hFE : 8'h00);
         expect_wr(259, 8'h02);
         cmp_writes((r == 0) ? "t2_norelu" : "t2_relu");
      end

      // T3: three chained layers 8->4->3->2
      set_layer(0, 8, 4, 0, 1'b0);
      set_layer(1, 4, 3, 1, 1'b1);
      set_layer(2, 3, 2, 2, 1'b0);
      num_layers = 3'd3;
      vec_tbl[0][0] = 1;    vec_tbl[0][1] = 2;     vec_tbl[0][2] = 3; vec_tbl[0][3] = 4;
      vec_tbl[1][0] = 10;   vec_tbl[1][1] = -20;   vec_tbl[1][2] = 30;
      vec_tbl[2][0] = 1000; vec_tbl[2][1] = -1000;
      launch();
      wait_done(300);
      for (int i = 0; i < 4; i++) expect_wr(256 + i, i + 1);
      expect_wr(0, 8'h05);
      expect_wr(1, 8'h00);
      expect_wr(2, 8'h0F);
      expect_wr(256, 8'h7F);
      expect_wr(257, 8'h80);
      cmp_writes("t3");
      check_eq("t3_starts", 32'(start_cnt - start_base), 3);
      check_eq("t3_rdbank_count", 32'(rdb_log.size() - rdb_base), 3);
      for (int i = 0; i < 3 && rdb_base + i < rdb_log.size(); i++)
         check_eq($sformatf("t3_rdbank%0d", i), 32'(rdb_log[rdb_base + i]), 32'(i % 2));
      check_eq("t3_result_bank", 32'(result_bank), 1);
      check_eq("t3_error", 32'(err_at_done), 0);

      // T4: layer 1 input size does not match layer 0 output size
      set_layer(0, 4, 4, 0, 1'b0);
      set_layer(1, 5, 2, 0, 1'b0);
      num_layers = 3'd2;
      launch();
      wait_done(200);
      for (int i = 0; i < 4; i++) expect_wr(256 + i, i + 1);
      cmp_writes("t4");
      check_eq("t4_starts", 32'(start_cnt - start_base), 1);
      check_eq("t4_error", 32'(err_at_done), 1);
      check_eq("t4_error_sticky", 32'(error), 1);

      // T5: illegal sizes fail before any compute; zero layers finishes clean
      for (int k = 0; k < 4; k++) begin
         set_layer(0, (k == 2) ? 257 : 4, (k == 0) ? 0 : ((k == 1) ? 65 : 2), 0, 1'b0);
         num_layers = (k == 3) ? 3'd0 : 3'd1;
         launch();
         wait_done(50);
         cmp_writes($sformatf("t5_%0d", k));
         check_eq($sformatf("t5_%0d_starts", k), 32'(start_cnt - start_base), 0);
         check_eq($sformatf("t5_%0d_error", k), 32'(err_at_done), (k == 3) ? 0 : 1);
      end

      // T6: start while busy is ignored; config captured at start
      set_layer(0, 4, 2, 0, 1'b0);
      num_layers = 3'd1;
      vec_tbl[0][0] = 7;
      vec_tbl[0][1] = 8;
      launch();
      cfg_output_size[0] = 7'd5;
      num_layers = 3'd3;
      @(posedge clk) #1;
      @(posedge clk) #1;
      start = 1'b1;
      @(posedge clk) #1;
      start = 1'b0;
      wait_done(100);
      expect_wr(256, 8'h07);
      expect_wr(257, 8'h08);
      cmp_writes("t6");
      check_eq("t6_starts", 32'(start_cnt - start_base), 1);
      check_eq("t6_result_bank", 32'(result_bank), 1);
      repeat (3) @(posedge clk);
      #1;
      check_eq("t6_idle", 32'(busy), 0);

      // T7: reset during layer 1 writeback, then a clean rerun
      set_layer(0, 8, 4, 0, 1'b0);
      set_layer(1, 4, 8, 0, 1'b0);
      set_layer(2, 8, 2, 0, 1'b0);
      num_layers = 3'd3;
      launch();
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (dc_if.tram_we && !dc_if.tram_waddr[8]) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk) #1;
      end
      check_eq("t7_reached_wb", 32'(seen), 1);
      check_eq("t7_layer_before", 32'(layer_idx), 1);
      check_eq("t7_rdbank_before", 32'(dc_if.rd_bank), 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_all_zero("t7_reset");
      @(posedge clk) #1;
      reset = 1'b0;
      @(posedge clk) #1;
      setup_t1();
      launch();
      wait_done(100);
      expect_wr(256, 8'h05);
      expect_wr(257, 8'hFD);
      cmp_writes("t7_rerun");
      check_eq("t7_rerun_starts", 32'(start_cnt - start_base), 1);
      check_eq("t7_rerun_error", 32'(err_at_done), 0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
